drm_32x4096_arb: RTL

DRM_32X4096_ARB -- requirements
Module: drm_32x4096_arb

---
 rtl/drm_32x4096_arb.sv | 130 +++++++++++++
 1 files changed

// File: rtl/drm_32x4096_arb.sv
// Two-requester arbiter for a 32x4096 simple dual-port RAM.
// Round-robin write and read ports with write-first forwarding.
module drm_32x4096_arb #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              wreq_valid,
  output logic [1:0]              wreq_ready,
  input  logic [2*ADDR_WIDTH-1:0] wreq_addr,
  input  logic [2*DATA_WIDTH-1:0] wreq_data,
  input  logic [1:0]              rreq_valid,
  output logic [1:0]              rreq_ready,
  input  logic [2*ADDR_WIDTH-1:0] rreq_addr,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    ram_wr_en,
  output logic [ADDR_WIDTH-1:0]   ram_wr_addr,
  output logic [DATA_WIDTH-1:0]   ram_wr_data,
  output logic [ADDR_WIDTH-1:0]   ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]   ram_rd_data
);

  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_rsp_valid;
  logic                  r_coll;
  logic [DATA_WIDTH-1:0] r_coll_data;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [DATA_WIDTH-1:0] r_rsp_hold;

  logic [1:0]            w_wgnt;
  logic [1:0]            w_rgnt;
  logic [ADDR_WIDTH-1:0] w_waddr0;
  logic [ADDR_WIDTH-1:0] w_waddr1;
  logic [DATA_WIDTH-1:0] w_wdata0;
  logic [DATA_WIDTH-1:0] w_wdata1;
  logic [ADDR_WIDTH-1:0] w_raddr0;
  logic [ADDR_WIDTH-1:0] w_raddr1;
  logic [ADDR_WIDTH-1:0] w_rsel;
  logic                  w_coll;
  logic                  w_rsp_live;

  assign w_waddr0 = wreq_addr[ADDR_WIDTH-1:0];
  assign w_waddr1 = wreq_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
  assign w_wdata0 = wreq_data[DATA_WIDTH-1:0];
  assign w_wdata1 = wreq_data[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_raddr0 = rreq_addr[ADDR_WIDTH-1:0];
  assign w_raddr1 = rreq_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];

  // Write grant: pointer breaks ties, nothing granted in reset.
  always_comb begin
    w_wgnt = 2'b00;
    if (!rst) begin
      unique case (wreq_valid)
        2'b01:   w_wgnt = 2'b01;
        2'b10:   w_wgnt = 2'b10;
        2'b11:   w_wgnt = r_wptr ? 2'b10 : 2'b01;
        default: w_wgnt = 2'b00;
      endcase
    end
  end

  // Read grant: same rule with its own pointer.
  always_comb begin
    w_rgnt = 2'b00;
    if (!rst) begin
      unique case (rreq_valid)
        2'b01:   w_rgnt = 2'b01;
        2'b10:   w_rgnt = 2'b10;
        2'b11:   w_rgnt = r_rptr ? 2'b10 : 2'b01;
        default: w_rgnt = 2'b00;
      endcase
    end
  end

  assign wreq_ready = w_wgnt;
  assign rreq_ready = w_rgnt;

  assign ram_wr_en   = |w_wgnt;
  assign ram_wr_addr = w_wgnt[1] ? w_waddr1 : w_waddr0;
  assign ram_wr_data = w_wgnt[1] ? w_wdata1 : w_wdata0;

  // Read address is held between grants so the RAM port stays quiet.
  assign w_rsel      = w_rgnt[1] ? w_raddr1 : w_raddr0;
  assign ram_rd_addr = (|w_rgnt) ? w_rsel : r_rd_addr;

  assign w_coll = (|w_rgnt) & (|w_wgnt) & (w_rsel == ram_wr_addr);

  // Round-robin pointers: the requester just served loses priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
    end else begin
      if (|w_wgnt) r_wptr <= w_wgnt[0];
      if (|w_rgnt) r_rptr <= w_rgnt[0];
    end
  end

  // Response strobe, collision capture and read-address hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 2'b00;
      r_coll      <= 1'b0;
      r_coll_data <= '0;
      r_rd_addr   <= '0;
    end else begin
      r_rsp_valid <= w_rgnt;
      r_coll      <= w_coll;
      r_coll_data <= ram_wr_data;
      r_rd_addr   <= ram_rd_addr;
    end
  end

  // A pending response is dropped as soon as reset is seen.
  assign rsp_valid  = r_rsp_valid & {2{~rst}};
  assign w_rsp_live = |rsp_valid;

  assign rsp_data = !w_rsp_live ? r_rsp_hold :
                    r_coll      ? r_coll_data : ram_rd_data;

  // Last presented read data, shown while no response is live.
  always_ff @(posedge clk) begin
    if (rst) r_rsp_hold <= '0;
    else     r_rsp_hold <= rsp_data;
  end

endmodule
